// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared constants, entry type and forwarding encoding for the register scoreboard
package reg_scoreboard_pkg;
  localparam int AGE_W = 2;
  localparam logic [4:0] XZR = 5'd31;
  localparam logic [AGE_W-1:0] AGE_EX = 2'd3;
  localparam logic [AGE_W-1:0] AGE_MEM = 2'd2;
  localparam logic [AGE_W-1:0] AGE_WB = 2'd1;
  localparam logic [AGE_W-1:0] AGE_FREE = 2'd0;
  typedef struct packed {
    logic [AGE_W-1:0] age;
    logic ld;
  } sb_entry_t;
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;
  // A used source hazards only against a load still sitting in EX; XZR never hazards.
  function automatic logic load_use(input logic used, input logic [4:0] r, input sb_entry_t e);
    return used && r != XZR && e.age == AGE_EX && e.ld;
  endfunction
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: ID-stage request and stall/pending response bundle for the scoreboard
interface reg_scoreboard_if;
  logic freeze;
  logic id_valid;
  logic id_RegWrite;
  logic id_MemRead;
  logic [4:0] id_Rd;
  logic [4:0] id_Rn;
  logic [4:0] id_Rm;
  logic [4:0] id_RdSrc;
  logic id_useRn;
  logic id_useRm;
  logic id_useRdSrc;
  logic stall;
  logic [31:0] pending;
  modport master (
    output freeze, id_valid, id_RegWrite, id_MemRead, id_Rd, id_Rn, id_Rm, id_RdSrc,
           id_useRn, id_useRm, id_useRdSrc,
    input stall, pending
  );
  modport slave (
    input freeze, id_valid, id_RegWrite, id_MemRead, id_Rd, id_Rn, id_Rm, id_RdSrc,
          id_useRn, id_useRm, id_useRdSrc,
    output stall, pending
  );
endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// sb_entry: one register's in-flight writer age and load flag
module sb_entry
  import reg_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      freeze,
  input  logic      issue,
  input  logic      issue_ld,
  output sb_entry_t e
);
  // New writer enters at EX and wins over aging; otherwise age drains to free, dropping ld on the way out.
  always_ff @(posedge clk)
    if (!reset) e <= '0;
    else if (!freeze) begin
      if (issue) e <= '{age: AGE_EX, ld: issue_ld};
      else if (e.age != AGE_FREE) e <= '{age: e.age - 1'b1, ld: e.ld && e.age != AGE_WB};
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: ID-stage in-flight writer tracking and load-use stall; SCOREBOARD_STATS_EN adds stall/issue counters
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  reg_scoreboard_if.slave     bus
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]         stall_count,
  output logic [31:0]         issue_count
`endif
);
  sb_entry_t ent [NREGS];
  logic [NREGS-1:0] pend;
  logic issue;
  assign ent[NREGS-1] = '0;
  assign pend[NREGS-1] = 1'b0;
  assign bus.stall = bus.id_valid && (load_use(bus.id_useRn, bus.id_Rn, ent[bus.id_Rn]) ||
                                      load_use(bus.id_useRm, bus.id_Rm, ent[bus.id_Rm]) ||
                                      load_use(bus.id_useRdSrc, bus.id_RdSrc, ent[bus.id_RdSrc]));
  assign issue = bus.id_valid && !bus.stall && !bus.freeze && bus.id_RegWrite && bus.id_Rd != XZR;
  assign bus.pending = pend;
  for (genvar i = 0; i < NREGS - 1; i++) begin : g_ent
    sb_entry u_entry (
      .clk      (clk),
      .reset    (reset),
      .freeze   (bus.freeze),
      .issue    (issue && bus.id_Rd == 5'(i)),
      .issue_ld (bus.id_MemRead),
      .e        (ent[i])
    );
    assign pend[i] = ent[i].age != AGE_FREE;
  end
`ifdef SCOREBOARD_STATS_EN
  // Saturating event counters; stalls count only on edges where the pipeline actually advances.
  always_ff @(posedge clk)
    if (!reset) begin
      stall_count <= '0;
      issue_count <= '0;
    end else begin
      if (bus.stall && !bus.freeze && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (issue && issue_count != '1) issue_count <= issue_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scoreboard bench for reg_scoreboard
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b0;
  reg_scoreboard_if bus ();
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_count, issue_count;
`endif
  reg_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_count (stall_count),
    .issue_count (issue_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st;
    logic [31:0] pd;
    string nm;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  // Monitor: every cycle the DUT presents stall/pending; compare against the oldest expectation.
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.stall !== e.st) begin
        errors++;
        $display("FAIL %s stall got=%0b want=%0b", e.nm, bus.stall, e.st);
      end
      checks++;
      if (bus.pending !== e.pd) begin
        errors++;
        $display("FAIL %s pending got=%h want=%h", e.nm, bus.pending, e.pd);
      end
    end
  task automatic drv(input logic v, rw, mr, input logic [4:0] rd, rn, rm, rs,
                     input logic un, um, us);
    bus.id_valid = v;
    bus.id_RegWrite = rw;
    bus.id_MemRead = mr;
    bus.id_Rd = rd;
    bus.id_Rn = rn;
    bus.id_Rm = rm;
    bus.id_RdSrc = rs;
    bus.id_useRn = un;
    bus.id_useRm = um;
    bus.id_useRdSrc = us;
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic ldur(input logic [4:0] rd);
    drv(1, 1, 1, rd, 5'd0, 0, 0, 0, 0, 0);
  endtask
  task automatic alu(input logic [4:0] rd, rn, rm);
    drv(1, 1, 0, rd, rn, rm, 0, 1, 1, 0);
  endtask
  task automatic cyc(input logic st, input logic [31:0] pd, input string nm);
    q.push_back('{st, pd, nm});
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.freeze = 1'b0;
    alu(5'd1, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    cyc(0, 32'h0, "rst_hold0");
    cyc(0, 32'h0, "rst_hold1");
    reset = 1'b1;
    drv(1, 1, 0, 5'd1, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h0, "add_x1");
    idle();
    cyc(0, 32'h2, "x1_ex");
    cyc(0, 32'h2, "x1_mem");
    cyc(0, 32'h2, "x1_wb");
    cyc(0, 32'h0, "x1_free");
    ldur(5'd2);
    cyc(0, 32'h0, "ld_x2");
    alu(5'd3, 5'd2, 5'd4);
    cyc(1, 32'h4, "lu_stall");
    cyc(0, 32'h4, "lu_release");
    idle();
    cyc(0, 32'hC, "lu_x3_issued");
    cyc(0, 32'h8, "lu_drain1");
    cyc(0, 32'h8, "lu_drain2");
    ldur(5'd2);
    cyc(0, 32'h0, "ld_x2_b");
    alu(5'd3, 5'd5, 5'd6);
    cyc(0, 32'h4, "gap_add");
    drv(1, 1, 0, 5'd7, 5'd2, 5'd8, 0, 1, 1, 0);
    cyc(0, 32'hC, "gap_sub");
    idle();
    cyc(0, 32'h8C, "gap_drain1");
    cyc(0, 32'h88, "gap_drain2");
    cyc(0, 32'h80, "gap_drain3");
    cyc(0, 32'h0, "gap_free");
    ldur(5'd9);
    cyc(0, 32'h0, "ld_x9");
    drv(1, 0, 0, 5'd0, 5'd10, 5'd0, 5'd9, 1, 0, 1);
    cyc(1, 32'h200, "stur_stall");
    cyc(0, 32'h200, "stur_release");
    ldur(5'd9);
    cyc(0, 32'h200, "ld_x9_again");
    drv(1, 0, 0, 5'd0, 5'd10, 5'd0, 5'd9, 1, 0, 0);
    cyc(0, 32'h200, "stur_nouse");
    idle();
    cyc(0, 32'h200, "x9_drain1");
    cyc(0, 32'h200, "x9_drain2");
    cyc(0, 32'h0, "x9_free");
    drv(1, 1, 0, 5'd31, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h0, "add_xzr");
    ldur(5'd31);
    cyc(0, 32'h0, "ld_xzr");
    drv(1, 0, 0, 5'd0, 5'd31, 5'd31, 5'd31, 1, 1, 1);
    cyc(0, 32'h0, "use_xzr");
    idle();
    cyc(0, 32'h0, "xzr_none");
    ldur(5'd4);
    cyc(0, 32'h0, "ld_x4");
    alu(5'd5, 5'd4, 5'd4);
    bus.freeze = 1'b1;
    cyc(1, 32'h10, "frz1");
    cyc(1, 32'h10, "frz2");
    cyc(1, 32'h10, "frz3");
    bus.freeze = 1'b0;
    cyc(1, 32'h10, "frz_unfrz");
    cyc(0, 32'h10, "frz_release");
    ldur(5'd4);
    cyc(0, 32'h30, "ld_x4_again");
    reset = 1'b0;
    alu(5'd6, 5'd4, 5'd0);
    cyc(1, 32'h30, "rst_mid");
    reset = 1'b1;
    cyc(0, 32'h0, "rst_after");
    idle();
    cyc(0, 32'h40, "post_rst_issue");
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side companion to the EX-stage forwarding logic in the 5-stage LEGv8 pipeline.
- Sits in ID and records every in-flight register write: which register, which stage it is in, and whether it is a load.
- Raises a load-use stall for the ID instruction when forwarding cannot yet supply an operand.
- Exports a per-register pending mask for debug and hazard checks.

Parameters:
- NREGS, 32, architectural register count; register 31 (XZR) is never tracked.
- AGE_W, 2, width of the per-register stage counter.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-low reset
- freeze  input  1  whole-pipeline hold (memory wait); state holds
- id_valid  input  1  ID holds a real instruction (not a bubble or flushed slot)
- id_RegWrite  input  1  ID instruction writes a register
- id_MemRead  input  1  ID instruction is a load (LDUR)
- id_Rd  input  5  ID destination register
- id_Rn  input  5  first source register
- id_Rm  input  5  second source register
- id_RdSrc  input  5  store-data register (STUR Rt)
- id_useRn  input  1  Rn is read
- id_useRm  input  1  Rm is read
- id_useRdSrc  input  1  store data is read
- stall  output  1  hold PC and IF/ID; inject a bubble into ID/EX
- pending  output  32  bit i is 1 while register i has an in-flight writer

Behaviour:
- Per-register state:
  - age[i], AGE_W bits. 0 = free, 3 = writer in EX, 2 = in MEM, 1 = in WB.
  - ld[i], 1 bit, set when the writer is a load.
- Reset (reset==0 at a clk edge): all age=0, all ld=0. pending=0 and stall=0 on the following cycle.
- Outputs:
  - pending[i] = (age[i]!=0). Registered-state derived, no combinational input path.
  - stall is combinational from the current state and id_* inputs, valid in the same cycle.
- Stall rule:
  - stall = id_valid & any used source s with s!=31, age[s]==3 and ld[s]==1.
  - Only an EX-stage load causes a stall. ALU writers at any age, and loads at age 2 or 1, are covered by forwarding or the register file.
- Issue rule:
  - Issue = id_valid & !stall & !freeze & id_RegWrite & id_Rd!=31.
  - On issue: age[id_Rd] <= 3, ld[id_Rd] <= id_MemRead.
- Advance (each edge with !freeze):
  - Every non-issued entry with age!=0 decrements by 1.
  - ld clears when age reaches 0.
- Freeze: no issue, no decrement; all state holds. stall still evaluates combinationally.
- Simultaneous events:
  - Issue to a register already pending overwrites it: the youngest writer wins, matching forwarding priority.
  - Issue beats decrement on the same register.
  - Stall and freeze together: state holds.
- Self-dependence: an ID instruction whose Rd equals its own source stalls against the older writer only; the new entry is written after the stall check.
- Stall duration: a load-use produces exactly one stall cycle. The load moves from age 3 to 2 and the stall condition drops.
- Reset mid-operation: all entries clear immediately; in-flight instructions are considered squashed by the pipeline reset.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined:
  - Adds output stall_count (32 bits), incrementing on every edge where stall & !freeze.
  - Saturates at 32'hFFFF_FFFF; cleared by reset.
  - Adds output issue_count (32 bits) with the same rules, counting issues.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - XZR = 5'd31
  - AGE_EX = 2'd3, AGE_MEM = 2'd2, AGE_WB = 2'd1, AGE_FREE = 2'd0
  - typedef sb_entry_t {age, ld}
  - typedef for the 2-bit forward-select encoding (00 regfile, 10 EX/MEM, 01 MEM/WB), shared with forwarding.
- One natural sub-module, sb_entry: a single register's age/ld flop pair with issue/advance/freeze logic, instantiated 31 times (generate).

Test Plan:
- Reset low for 2 cycles, then issue ADD X1 (RegWrite, Rd=1) -> pending=0 during reset; after the issue edge pending[1]=1 for exactly 3 cycles, then 0.
- LDUR X2, then next-cycle ADD X3,X2,X4 (useRn, Rn=2) -> stall=1 for exactly one cycle; the ADD issues the next cycle with pending[3]=1.
- LDUR X2, then ADD X3,X5,X6, then SUB X7,X2,X8 -> stall stays 0 throughout (load already at age 2 when SUB is in ID).
- LDUR X9, then STUR X9 as store data (useRdSrc, RdSrc=9) -> stall=1 for one cycle; with id_useRdSrc=0 -> stall=0.
- Issue writes to Rd=31 and a load to X31 followed by a use of X31 -> pending[31] never 1, stall never 1.
- LDUR X4 with freeze=1 for 3 cycles while ADD using X4 sits in ID -> stall=1 and age[4] holds at 3 throughout the freeze; stall drops one unfrozen cycle later. Assert reset mid-sequence -> pending=0 and stall=0 next cycle.
